uart_tx: RTL and testbench

Serial transmitter for the UART-on-FPGA design. It consumes the single-cycle press pulse from the push-button debouncer and the byte on the board switches, then sends that byte as one 8N1 frame (1 start, 8 data LSB-first, 1 stop, no parity) on the UART TX pin. It sits directly downstream of the debouncer and drives the board's serial output.

---
 rtl/uart_tx.sv | 103 ++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: tx and tx_busy change on the edge that accepts tx_start; frame is 10*CLKS_PER_BIT cycles.
// No backpressure: tx_start while busy is dropped, and tx_data is only sampled when a start is accepted.
module uart_tx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             tx_nxt, busy_nxt, done_nxt;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
            tx_busy <= busy_nxt;
            tx_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_end ? '0 : cnt + CNT_W'(1);
        idx_nxt   = idx;
        shift_nxt = shift;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (tx_start) begin
                    shift_nxt = tx_data;
                    idx_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    if (idx == 3'd7) state_nxt = STOP;
                    else             idx_nxt   = idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx is a clean register output.
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a line-decoding monitor checked against a queue of expected bytes.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_busy, tx_done;

    int checks = 0;
    int errors = 0;
    int frames_done = 0;
    int spurious_done = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ (1000),
        .BAUD_RATE(100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        exp_q.push_back(d);
        @(posedge clk);
        #1 tx_start = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (frames_done < n && k < 400) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frame_count", frames_done, n);
    endtask

    // Monitor: decodes the line at mid-bit and checks the whole waveform cycle by cycle.
    initial begin : monitor
        int         pos;
        logic [7:0] rx;
        logic [7:0] exp_b;
        logic       e;
        bit         busy_bad, wave_bad, have_exp, at_end;
        pos = -1;
        rx = '0;
        exp_b = '0;
        busy_bad = 0;
        wave_bad = 0;
        have_exp = 0;
        forever begin
            @(negedge clk);
            at_end = 0;
            if (reset !== 1'b1) begin
                pos = -1;
            end else begin
                if (pos < 0) begin
                    if (tx === 1'b0) begin
                        pos = 0;
                        rx = '0;
                        busy_bad = 0;
                        wave_bad = 0;
                        have_exp = (exp_q.size() > 0);
                        exp_b = have_exp ? exp_q[0] : 8'h00;
                        check("frame_expected", {31'd0, have_exp}, 1);
                    end
                end else begin
                    pos++;
                end
                if (pos >= 0 && pos < 100) begin
                    if (tx_busy !== 1'b1) busy_bad = 1;
                    if (pos < 10)      e = 1'b0;
                    else if (pos < 90) e = exp_b[(pos - 10) / 10];
                    else               e = 1'b1;
                    if (tx !== e) wave_bad = 1;
                    if (pos >= 15 && pos < 90 && (pos % 10) == 5) rx[(pos - 15) / 10] = tx;
                    if (pos == 5)  check("start_bit", {31'd0, tx}, 0);
                    if (pos == 95) check("stop_bit", {31'd0, tx}, 1);
                end else if (pos == 100) begin
                    at_end = 1;
                    check("done_pulse", {31'd0, tx_done}, 1);
                    check("busy_end", {31'd0, tx_busy}, 0);
                    check("busy_len", {31'd0, busy_bad}, 0);
                    check("waveform", {31'd0, wave_bad}, 0);
                    if (have_exp) check("rx_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
                    frames_done++;
                    pos = -1;
                end
            end
            if (tx_done === 1'b1 && !at_end) spurious_done++;
        end
    end

    initial begin : stim
        bit idle_bad;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset_tx", {31'd0, tx}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 1);
        check("reset_busy", {31'd0, tx_busy}, 0);
        check("reset_done", {31'd0, tx_done}, 0);
        idle_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) idle_bad = 1;
        end
        check("idle_quiet", {31'd0, idle_bad}, 0);

        send(8'hA5);
        wait_frames(1);

        send(8'h3C);
        repeat (38) @(posedge clk);
        #1;
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
        wait_frames(2);

        // Held start: the second frame is accepted in the done cycle of the first.
        tx_data  = 8'h00;
        tx_start = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h81);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (tx_done === 1'b1) break;
        end
        check("b2b_done_seen", {31'd0, tx_done}, 1);
        tx_data = 8'h81;
        @(posedge clk);
        #1 tx_start = 1'b0;
        check("b2b_no_gap", {30'd0, tx, tx_busy}, 32'h1);
        wait_frames(4);

        send(8'h55);
        repeat (34) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 1);
        check("midrst_busy", {31'd0, tx_busy}, 0);
        check("midrst_done", {31'd0, tx_done}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("frames_after_abort", frames_done, 4);
        send(8'h0F);
        wait_frames(5);

        send(8'hC3);
        repeat (100) begin
            @(posedge clk);
            #1 tx_data = ~tx_data;
        end
        wait_frames(6);

        repeat (30) @(posedge clk);
        #1;
        check("final_frames", frames_done, 6);
        check("spurious_done", spurious_done, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
